dma_controller: RTL and testbench

- Bus-mastering block-copy engine on the shared single-port memory bus, peer of the CPU master.
- Copies LENGTH 32-bit words from a source to a destination address, as a read/write pair per word.
- Obtains the bus through a request/grant pair from the bus arbiter and tristates all bus outputs when not granted.
- Yields the bus periodically so the CPU's LOAD/STORE traffic is not starved.

---
 rtl/dma_controller.sv | 145 ++++++++++++++
 tb/tb_dma_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
// Bus-mastering block-copy engine: moves `length` words from src to dst, one read/write pair
// per word, on an arbitrated single-port memory bus with periodic yields.
module dma_controller #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BURST      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [7:0]            length,
  output logic                  bus_req,
  input  logic                  bus_grant,
  output wire  [ADDR_WIDTH-1:0] mem_address,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output wire                   mem_read_enable,
  output wire                   mem_write_enable,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, YIELD, DONE} state_t;

  localparam logic [7:0]            BURST_LIMIT = 8'(BURST);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r;
  state_t                  resume_r;
  logic [ADDR_WIDTH-1:0]   src_r;
  logic [ADDR_WIDTH-1:0]   dst_r;
  logic [7:0]              remaining_r;
  logic [7:0]              burst_cnt_r;
  logic [DATA_WIDTH-1:0]   data_buf_r;
  logic                    bus_req_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    oe_s;
  logic                    wr_phase_s;

  // Output enable follows grant combinationally so the bus is released the same cycle grant drops.
  assign oe_s        = bus_grant & ((state_r == READ) | (state_r == WRITE));
  assign wr_phase_s  = (state_r == WRITE);

  assign mem_address      = oe_s ? (wr_phase_s ? dst_r : src_r) : {ADDR_WIDTH{1'bz}};
  assign mem_data         = (oe_s & wr_phase_s) ? data_buf_r : {DATA_WIDTH{1'bz}};
  assign mem_read_enable  = oe_s ? ~wr_phase_s : 1'bz;
  assign mem_write_enable = oe_s ? wr_phase_s : 1'bz;

  assign bus_req = bus_req_r;
  assign busy    = busy_r;
  assign done    = done_r;

  // Transfer sequencer; status outputs are registered alongside each state transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      resume_r    <= READ;
      src_r       <= {ADDR_WIDTH{1'b0}};
      dst_r       <= {ADDR_WIDTH{1'b0}};
      remaining_r <= 8'd0;
      burst_cnt_r <= 8'd0;
      data_buf_r  <= {DATA_WIDTH{1'b0}};
      bus_req_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (length != 8'd0) begin
              src_r       <= src_addr;
              dst_r       <= dst_addr;
              remaining_r <= length;
              burst_cnt_r <= 8'd0;
              resume_r    <= READ;
              state_r     <= REQ;
              bus_req_r   <= 1'b1;
              busy_r      <= 1'b1;
            end else begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus_grant) begin
            state_r <= resume_r;
          end
        end
        READ: begin
          if (bus_grant) begin
            data_buf_r <= mem_data;
            state_r    <= WRITE;
          end else begin
            resume_r <= READ;
            state_r  <= REQ;
          end
        end
        WRITE: begin
          if (bus_grant) begin
            src_r       <= src_r + ADDR_STEP;
            dst_r       <= dst_r + ADDR_STEP;
            remaining_r <= remaining_r - 8'd1;
            if (remaining_r == 8'd1) begin
              burst_cnt_r <= burst_cnt_r + 8'd1;
              state_r     <= DONE;
              bus_req_r   <= 1'b0;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end else if ((burst_cnt_r + 8'd1) == BURST_LIMIT) begin
              burst_cnt_r <= 8'd0;
              resume_r    <= READ;
              state_r     <= YIELD;
              bus_req_r   <= 1'b0;
            end else begin
              burst_cnt_r <= burst_cnt_r + 8'd1;
              state_r     <= READ;
            end
          end else begin
            // Void write: the buffered word is retried after re-grant without a re-read.
            resume_r <= WRITE;
            state_r  <= REQ;
          end
        end
        YIELD: begin
          state_r   <= REQ;
          bus_req_r <= 1'b1;
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          bus_req_r <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: table of transfers plus grant-drop and reset sequences.
module tb_dma_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        bus_grant;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [7:0]  length;
  logic        bus_req;
  logic        busy;
  logic        done;
  wire  [7:0]  mem_address;
  wire  [31:0] mem_data;
  wire         mem_read_enable;
  wire         mem_write_enable;
  logic        hiz;

  logic [31:0] mem [256];
  bit          written [256];
  int          wr_count [256];
  int          n_reads = 0;
  int          n_writes = 0;
  logic [7:0]  rd_addrs [$];

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] s;
    logic [7:0] d;
    logic [7:0] n;
    int         exp_done;
    int         exp_yield;
  } vec_t;
  vec_t vecs [7];

  dma_controller #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BURST(4)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .bus_req(bus_req), .bus_grant(bus_grant), .mem_address(mem_address),
    .mem_data(mem_data), .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return written[a] ? mem[a] : pat(a);
  endfunction

  assign hiz = (mem_address === 8'bz) && (mem_read_enable === 1'bz) && (mem_write_enable === 1'bz);
  assign mem_data = (mem_read_enable === 1'b1) ? mem_word(mem_address) : 32'bz;

  // Memory model: records read order and commits writes at the edge ending a write cycle.
  always @(posedge clk) begin
    if (mem_read_enable === 1'b1) begin
      rd_addrs.push_back(mem_address);
      n_reads <= n_reads + 1;
    end
    if (mem_write_enable === 1'b1) begin
      mem[mem_address]      <= mem_data;
      written[mem_address]  <= 1'b1;
      wr_count[mem_address] <= wr_count[mem_address] + 1;
      n_writes <= n_writes + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issues one start and samples each cycle at posedge+1 until done; optional grant drop on write #drop_wr.
  task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                          input int drop_wr, output int done_cyc, output int yields,
                          output int reqs, output int drv);
    int cyc;
    int wr_seen;
    int drop_left;
    int leak;
    done_cyc = 0; yields = 0; reqs = 0; drv = 0;
    cyc = 0; wr_seen = 0; drop_left = 0; leak = 0;
    @(negedge clk);
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_cyc == 0 && cyc < 300) begin
      cyc++;
      if (done === 1'b1) done_cyc = cyc;
      if (busy === 1'b1 && bus_req === 1'b0) yields++;
      if (bus_req === 1'b1) reqs++;
      if (!hiz) drv++;
      if (bus_req === 1'b0 && !hiz) leak++;
      if (drop_left > 0) begin
        drop_left--;
        if (drop_left == 0) bus_grant = 1'b1;
      end else if (drop_wr > 0 && mem_write_enable === 1'b1) begin
        wr_seen++;
        if (wr_seen == drop_wr) begin
          bus_grant = 1'b0;
          drop_left = 2;
          #1;
          check("drop_same_cycle_hiz", hiz, 1'b1);
        end
      end
      if (done_cyc == 0) begin
        @(posedge clk); #1;
      end
    end
    check("done_seen", (done_cyc != 0), 1'b1);
    check("bus_undriven_without_req", leak, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic check_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                            input int rbase);
    logic [7:0] ea;
    for (int i = 0; i < int'(n); i++) begin
      ea = s + 8'(i);
      if (rbase + i < rd_addrs.size()) check("read_order", rd_addrs[rbase + i], ea);
      else check("read_missing", 0, 1);
      check("dst_data", mem_word(d + 8'(i)), pat(ea));
    end
  endtask

  initial begin
    int dc, yc, rq, dv, rb, nr, nw, k, done_hits;

    vecs[0] = '{s: 8'h10, d: 8'h40, n: 8'd3, exp_done: 8,  exp_yield: 0};
    vecs[1] = '{s: 8'h80, d: 8'h90, n: 8'd0, exp_done: 1,  exp_yield: 0};
    vecs[2] = '{s: 8'h50, d: 8'h60, n: 8'd6, exp_done: 16, exp_yield: 1};
    vecs[3] = '{s: 8'hFE, d: 8'h20, n: 8'd4, exp_done: 10, exp_yield: 0};
    vecs[4] = '{s: 8'hA0, d: 8'hB0, n: 8'd8, exp_done: 20, exp_yield: 1};
    vecs[5] = '{s: 8'h70, d: 8'hC0, n: 8'd5, exp_done: 14, exp_yield: 1};
    vecs[6] = '{s: 8'h30, d: 8'hE0, n: 8'd9, exp_done: 24, exp_yield: 2};

    reset = 1'b1; start = 1'b0; bus_grant = 1'b1;
    src_addr = 8'h00; dst_addr = 8'h00; length = 8'd0;
    #2 reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_bus_req", bus_req, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_hiz", hiz, 1'b1);
    @(negedge clk) reset = 1'b1;

    for (int v = 0; v < 7; v++) begin
      rb = rd_addrs.size(); nr = n_reads; nw = n_writes;
      run_xfer(vecs[v].s, vecs[v].d, vecs[v].n, 0, dc, yc, rq, dv);
      check("done_cycle", dc, vecs[v].exp_done);
      check("yield_cycles", yc, vecs[v].exp_yield);
      check("read_count", n_reads - nr, vecs[v].n);
      check("write_count", n_writes - nw, vecs[v].n);
      if (vecs[v].n == 8'd0) begin
        check("len0_no_req", rq, 0);
        check("len0_bus_hiz", dv, 0);
      end
      check_copy(vecs[v].s, vecs[v].d, vecs[v].n, rb);
    end

    // Grant withdrawn for two cycles during the second write.
    rb = rd_addrs.size(); nr = n_reads; nw = n_writes;
    run_xfer(8'h10, 8'hF0, 8'd3, 2, dc, yc, rq, dv);
    check("drop_done_cycle", dc, 11);
    check("drop_read_count", n_reads - nr, 3);
    check("drop_write_count", n_writes - nw, 3);
    check("drop_word2_once", wr_count[8'hF1], 1);
    check_copy(8'h10, 8'hF0, 8'd3, rb);

    // Reset asserted mid-transfer right after the first word lands.
    @(negedge clk);
    src_addr = 8'h10; dst_addr = 8'hD0; length = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nw = n_writes;
    k = 0;
    while (n_writes == nw && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("rst_word1_written", n_writes - nw, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_hiz", hiz, 1'b1);
    done_hits = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_hits++;
    end
    check("rst_no_done", done_hits, 0);
    check("rst_word2_not_written", wr_count[8'hD1], 0);
    @(negedge clk) reset = 1'b1;
    rb = rd_addrs.size();
    run_xfer(8'h10, 8'hD0, 8'd3, 0, dc, yc, rq, dv);
    check("post_rst_done_cycle", dc, 8);
    check_copy(8'h10, 8'hD0, 8'd3, rb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
